// File: rtl/arb_mux_n.sv
// N-input WIDTH-bit selector with a registered output, direct or round-robin grant.
// Optional ARB_MUX_LOCK_EN adds in_last to hold a round-robin grant across multi-beat packets.
module arb_mux_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 8,
    parameter int unsigned SELW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
`ifdef ARB_MUX_LOCK_EN
    input  logic [N-1:0]         in_last,
`endif
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan
);

    localparam int unsigned LAST_RST = N - 1;

    logic [SELW-1:0]  last;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_any;
    logic [SELW-1:0]  hi_idx;
    logic             hi_any;
    logic [SELW-1:0]  lo_idx;
    logic             lo_any;
    logic             can_accept;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;
`ifdef ARB_MUX_LOCK_EN
    logic             locked;
    logic             xfer_last;
`endif

    assign can_accept = !out_valid || out_ready;
    assign transfer   = gnt_any && can_accept && !reset;
    assign in_ready   = reset ? '0 : (grant & {N{can_accept}});

    // Round-robin splits requesters above the pointer (searched first) from those at or below it.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        hi_idx  = '0;
        hi_any  = 1'b0;
        lo_idx  = '0;
        lo_any  = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (in_valid[i] && (SELW'(i) > last)) begin
                hi_any = 1'b1;
                hi_idx = SELW'(i);
            end
            if (in_valid[i] && (SELW'(i) <= last)) begin
                lo_any = 1'b1;
                lo_idx = SELW'(i);
            end
        end
        if (!mode) begin
            for (int i = 0; i < int'(N); i++) begin
                if (in_valid[i] && (sel == SELW'(i))) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end
`ifdef ARB_MUX_LOCK_EN
        else if (locked) begin
            for (int i = 0; i < int'(N); i++) begin
                if (in_valid[i] && (last == SELW'(i))) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end
`endif
        else if (hi_any) begin
            gnt_any = 1'b1;
            gnt_idx = hi_idx;
        end else if (lo_any) begin
            gnt_any = 1'b1;
            gnt_idx = lo_idx;
        end
        for (int i = 0; i < int'(N); i++) begin
            grant[i] = gnt_any && (gnt_idx == SELW'(i));
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

`ifdef ARB_MUX_LOCK_EN
    assign xfer_last = |(in_last & grant);
`endif

    // Output register and arbitration pointer; drain and fill may happen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= SELW'(LAST_RST);
`ifdef ARB_MUX_LOCK_EN
            locked    <= 1'b0;
`endif
        end else begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= gnt_idx;
                last      <= gnt_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ARB_MUX_LOCK_EN
            if (!mode) begin
                locked <= 1'b0;
            end else if (transfer) begin
                locked <= !xfer_last;
            end
`endif
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: expected beats queued by stimulus, popped by an output monitor.
module tb_arb_mux_n;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = 8;
    localparam int unsigned SELW  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  chan;
    } beat_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               mode = 1'b1;
    logic [SELW-1:0]    sel = '0;
    logic [N-1:0]       in_valid = '1;
    logic [N*WIDTH-1:0] in_data = '0;
    logic [N-1:0]       in_last = '0;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;

    int    passed = 0;
    int    total  = 0;
    beat_t exp_q[$];

    arb_mux_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] data_of(input int i);
        if (i == 5) return 32'hDEAD_BEEF;
        return {8'hC0, 8'(i), 16'h5A5A};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push(input int ch);
        beat_t b;
        b.data = data_of(ch);
        b.chan = SELW'(ch);
        exp_q.push_back(b);
    endtask

    // A beat is consumed when the register is valid and the consumer is ready at the next edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat: got chan %0d data 0x%08h, none expected", out_chan, out_data);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat_data", out_data, b.data);
                check("beat_chan", 32'(out_chan), 32'(b.chan));
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(N); i++) in_data[i*WIDTH +: WIDTH] = data_of(i);

        // Reset with every channel requesting.
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_chan", 32'(out_chan), 32'h0);
        reset = 1'b0;
        settle();
        check("rr_first_grant", 32'(in_ready), 32'h01);
        push(0);
        tick();
        in_valid = '0;
        tick();

        // Direct select, then an out-of-range select.
        mode = 1'b0;
        sel = 4'd5;
        in_valid = '1;
        settle();
        check("direct_sel5", 32'(in_ready), 32'h20);
        push(5);
        tick();
        sel = 4'd9;
        settle();
        check("direct_sel9", 32'(in_ready), 32'h00);
        check("direct_out_data", out_data, 32'hDEAD_BEEF);
        in_valid = '0;
        tick();

        // Park the pointer on channel 7 so round-robin starts at 0.
        sel = 4'd7;
        in_valid = '1;
        settle();
        check("direct_sel7", 32'(in_ready), 32'h80);
        push(7);
        tick();

        // Round-robin fairness, one beat per cycle.
        mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            settle();
            check("rr_in_ready", 32'(in_ready), 32'(8'h01 << (k % 8)));
            push(k % 8);
            tick();
            check("rr_no_bubble", 32'(out_valid), 32'h1);
            check("rr_chan", 32'(out_chan), 32'(k % 8));
        end

        // Back-pressure: one beat, three stall cycles, then drain and fill together.
        settle();
        check("bp_first", 32'(in_ready), 32'h01);
        push(0);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("bp_stall_ready", 32'(in_ready), 32'h0);
            check("bp_stall_valid", 32'(out_valid), 32'h1);
            check("bp_stall_data", out_data, data_of(0));
            tick();
        end
        out_ready = 1'b1;
        settle();
        check("bp_release", 32'(in_ready), 32'h02);
        push(1);
        tick();
        check("bp_refill_valid", 32'(out_valid), 32'h1);
        check("bp_refill_chan", 32'(out_chan), 32'h1);
        in_valid = '0;
        tick();

        // Sparse wrap from pointer 6.
        mode = 1'b0;
        sel = 4'd6;
        in_valid = '1;
        push(6);
        tick();
        mode = 1'b1;
        in_valid = 8'b0000_0101;
        settle();
        check("wrap_g0", 32'(in_ready), 32'h01);
        push(0);
        tick();
        check("wrap_g2", 32'(in_ready), 32'h04);
        push(2);
        tick();
        check("wrap_g0_again", 32'(in_ready), 32'h01);
        push(0);
        tick();
        in_valid = '0;
        tick();

`ifdef ARB_MUX_LOCK_EN
        // Channel 3 holds the grant across a three-beat packet.
        mode = 1'b0;
        sel = 4'd2;
        in_valid = '1;
        push(2);
        tick();
        mode = 1'b1;
        in_last = 8'h00;
        settle();
        check("lock_b0", 32'(in_ready), 32'h08);
        push(3);
        tick();
        check("lock_b1", 32'(in_ready), 32'h08);
        push(3);
        tick();
        in_last = 8'h08;
        settle();
        check("lock_b2", 32'(in_ready), 32'h08);
        push(3);
        tick();
        in_last = 8'h00;
        settle();
        check("lock_release", 32'(in_ready), 32'h10);
        push(4);
        tick();
        in_valid = '0;
        tick();
`endif

        // Reset mid-stream discards the held beat and rewinds the pointer.
        out_ready = 1'b0;
        in_valid = '1;
        tick();
        check("mid_held", 32'(out_valid), 32'h1);
        reset = 1'b1;
        settle();
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_chan", 32'(out_chan), 32'h0);
        reset = 1'b0;
        out_ready = 1'b1;
        settle();
        check("mid_rst_grant", 32'(in_ready), 32'h01);
        push(0);
        tick();
        in_valid = '0;
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-input, WIDTH-bit selector with a registered output and valid/ready handshakes. It generalises the fixed 8:1 32-bit operand mux into a sequential block with two modes: externally selected (direct) or round-robin arbitrated. It sits between multiple producers (forwarding sources, memory return ports, coprocessor results) and a single consumer stage of the datapath, and provides one cycle of registered latency with full-throughput back-pressure.

## Interface
- WIDTH, 32, data width per channel
- N, 8, number of input channels (2..16)
- SELW, 3, select/channel-index width; must satisfy 2**SELW >= N
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mode  in  1  0 = direct select via `sel`, 1 = round-robin arbitration
- sel  in  SELW  channel index used when mode = 0
- in_valid  in  N  per-channel data valid
- in_data  in  N*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept; one-hot or zero
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts beat
- out_data  out  WIDTH  registered selected data
- out_chan  out  SELW  index of channel that supplied out_data

## Operation
- Single-entry output register (out_valid, out_data, out_chan).
- can_accept = !out_valid | out_ready (combinational, same cycle).
- Grant (combinational, at most one channel):
  - mode 0: grant channel `sel` iff sel < N and in_valid[sel]; sel >= N grants nothing.
  - mode 1: search in_valid starting at (last+1) mod N, wrapping; first set channel wins; none set grants nothing.
- in_ready[i] = grant[i] & can_accept. in_ready never depends on in_valid of other channels beyond the arbitration search.
- Transfer on channel i when in_valid[i] & in_ready[i]: out_data <= channel i data, out_chan <= i, out_valid <= 1.
- If out_valid & out_ready and no input transfer: out_valid <= 0; out_data/out_chan hold last values.
- `last` (round-robin pointer, SELW bits) updates to the granted index only on a transfer, in either mode; it is never altered by stalls.
- Mode or sel changes take effect on the next grant evaluation; a beat already in the output register is unaffected.

## Timing
- Reset (synchronous, priority over all else): out_valid = 0, out_data = 0, out_chan = 0, last = N-1 (so channel 0 has first priority); in_ready = 0 during the reset cycle.
- Latency: input transfer at edge k -> out_valid/out_data valid after edge k, visible in cycle k+1.
- Throughput: one beat per cycle while out_ready = 1; simultaneous drain and fill in the same cycle is required (no bubble).
- Stall: out_valid = 1, out_ready = 0 -> all in_ready = 0; output register stable.
- Reset asserted mid-stream: output beat discarded, pointer returns to N-1, no in_ready issued that cycle.
- Producers must hold in_data stable while in_valid = 1 and in_ready = 0.

## Configuration
- ARB_MUX_LOCK_EN defined: adds input port in_last (N bits). In mode 1, once a transfer with in_last[i] = 0 occurs on channel i, the grant is locked to channel i (other channels receive in_ready = 0) until a transfer with in_last[i] = 1 on that channel; then normal round-robin resumes from i. Lock flag clears on reset. Mode 0 ignores in_last and clears the lock.
- Not defined: no in_last port; every beat is independently arbitrated.

## Test plan
- Reset: assert reset 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0; first grant in mode 1 goes to channel 0.
- Direct select: mode 0, sel = 5, in_valid = 8'hFF, channel 5 data 32'hDEAD_BEEF, out_ready = 1 -> in_ready = 8'h20; next cycle out_data = 32'hDEAD_BEEF, out_chan = 5; sel = 9 with N = 8 -> in_ready = 0.
- Round-robin fairness: mode 1, in_valid = 8'hFF held, out_ready = 1 for 16 cycles -> out_chan sequence 0,1,...,7,0,...,7, one beat per cycle, no bubbles.
- Back-pressure: mode 1, out_ready = 0 for 3 cycles after one beat -> out_valid stays 1, out_data unchanged, in_ready = 0; release out_ready -> drain and next beat load in the same edge.
- Sparse wrap: mode 1, last = 6, in_valid = 8'b0000_0101 -> grant channel 0, then channel 2, then channel 0.
- ARB_MUX_LOCK_EN: channel 3 sends 3 beats with in_last = 0,0,1 while in_valid = 8'hFF -> out_chan = 3,3,3 then 4.
